// File: rtl/coin_input_conditioner_pkg.sv
// Shared vending-machine definitions: coin codes, coin values and button/switch bit positions.
// Used by the coin input conditioner and the vending FSM.
package vm_pkg;

    localparam int NUM_BTN = 4;
    localparam int NUM_SW  = 3;

    localparam logic [1:0] COIN_NICKEL  = 2'd0;
    localparam logic [1:0] COIN_DIME    = 2'd1;
    localparam logic [1:0] COIN_QUARTER = 2'd2;
    localparam logic [1:0] COIN_CLEAR   = 2'd3;

    localparam logic [7:0] NICKEL_CENTS  = 8'd5;
    localparam logic [7:0] DIME_CENTS    = 8'd10;
    localparam logic [7:0] QUARTER_CENTS = 8'd25;

    localparam int BTN_NICKEL  = 3;
    localparam int BTN_DIME    = 2;
    localparam int BTN_QUARTER = 1;
    localparam int BTN_CLEAR   = 0;

    localparam int SW_BEAN    = 2;
    localparam int SW_CHICKEN = 1;
    localparam int SW_STEAK   = 0;

    // Clear carries no money, so it maps to zero cents.
    function automatic logic [7:0] coin_cents(input logic [1:0] code);
        logic [7:0] cents;
        cents = 8'd0;
        case (code)
            COIN_NICKEL:  cents = NICKEL_CENTS;
            COIN_DIME:    cents = DIME_CENTS;
            COIN_QUARTER: cents = QUARTER_CENTS;
            default:      cents = 8'd0;
        endcase
        return cents;
    endfunction

endpackage

// File: rtl/coin_input_conditioner_debounce_cell.sv
// One input channel: 2-flop synchroniser followed by a stability counter that
// only moves the debounced level after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample matching the current level restarts the count, so only an
    // unbroken run of differing samples can flip the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces coin buttons and product switches, turns each button press into one
// queued event on a valid/ready handshake. COIN_TALLY_EN adds saturating coin tallies.
module coin_input_conditioner
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    input  logic [2:0] sw_raw,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic [2:0] sel,
    output logic       overrun
`ifdef COIN_TALLY_EN
    ,
    output logic [23:0] tally
`endif
);

    logic [NUM_BTN-1:0] btn_lvl;
    logic [NUM_SW-1:0]  sw_lvl;
    logic [NUM_BTN-1:0] btn_prev_q;
    logic [NUM_BTN-1:0] pending_q;
    logic [NUM_BTN-1:0] pending_d;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] take;
    logic               overrun_q;
    logic               overrun_d;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (btn_raw[b]),
            .level_o(btn_lvl[b])
        );
    end

    for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (sw_raw[s]),
            .level_o(sw_lvl[s])
        );
    end

    // Fixed-priority arbiter: nickel beats dime beats quarter beats clear.
    always_comb begin
        evt_valid = |pending_q;
        evt_code  = COIN_NICKEL;
        grant     = '0;
        if (pending_q[BTN_NICKEL]) begin
            evt_code          = COIN_NICKEL;
            grant[BTN_NICKEL] = 1'b1;
        end else if (pending_q[BTN_DIME]) begin
            evt_code        = COIN_DIME;
            grant[BTN_DIME] = 1'b1;
        end else if (pending_q[BTN_QUARTER]) begin
            evt_code           = COIN_QUARTER;
            grant[BTN_QUARTER] = 1'b1;
        end else if (pending_q[BTN_CLEAR]) begin
            evt_code         = COIN_CLEAR;
            grant[BTN_CLEAR] = 1'b1;
        end
    end

    // A new press on the cycle its bit is consumed re-sets the bit, so it is
    // not an overrun; only a press onto an untouched pending bit is dropped.
    always_comb begin
        take      = grant & {NUM_BTN{evt_valid & evt_ready}};
        rise      = btn_lvl & ~btn_prev_q;
        pending_d = (pending_q & ~take) | rise;
        overrun_d = |(rise & pending_q & ~take);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            pending_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            btn_prev_q <= btn_lvl;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
        end
    end

    assign overrun = overrun_q;
    assign sel     = sw_lvl;

`ifdef COIN_TALLY_EN
    logic [7:0] nickels_q;
    logic [7:0] dimes_q;
    logic [7:0] quarters_q;

    // Tallies only count accepted coins and hold at 255; clear events leave them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nickels_q  <= 8'd0;
            dimes_q    <= 8'd0;
            quarters_q <= 8'd0;
        end else begin
            if (take[BTN_NICKEL] && nickels_q != 8'hFF) begin
                nickels_q <= nickels_q + 8'd1;
            end
            if (take[BTN_DIME] && dimes_q != 8'hFF) begin
                dimes_q <= dimes_q + 8'd1;
            end
            if (take[BTN_QUARTER] && quarters_q != 8'hFF) begin
                quarters_q <= quarters_q + 8'd1;
            end
        end
    end

    assign tally = {nickels_q, dimes_q, quarters_q};
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3;
// the tally section only runs when COIN_TALLY_EN is defined.
module tb_coin_input_conditioner;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [2:0] sw_raw;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic [2:0] sel;
    logic       overrun;
`ifdef COIN_TALLY_EN
    logic [23:0] tally;
`endif

    int total;
    int bad;
    int ovrA;
    int ovrB;
    int ovrC;
    int vld;

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_ready(evt_ready),
        .sel      (sel),
        .overrun  (overrun)
`ifdef COIN_TALLY_EN
        ,
        .tally    (tally)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks, sampling 1 time unit after each rising edge and
    // counting overrun pulses and cycles with an event presented.
    task automatic applyStimulus(input int n, output int ovrCount, output int vldCount);
        ovrCount = 0;
        vldCount = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (overrun === 1'b1) ovrCount++;
            if (evt_valid === 1'b1) vldCount++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic handshake();
        int o;
        int v;
        evt_ready = 1'b1;
        applyStimulus(1, o, v);
        evt_ready = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        btn_raw   = 4'b0000;
        sw_raw    = 3'b000;
        evt_ready = 1'b0;

        applyStimulus(3, ovrA, vld);
        checkOutput("reset_valid", 32'(evt_valid), 32'd0);
        checkOutput("reset_code", 32'(evt_code), 32'd0);
        checkOutput("reset_sel", 32'(sel), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        applyStimulus(3, ovrA, vld);

        // Three-cycle glitch on dime must be filtered out.
        btn_raw = 4'b0100;
        applyStimulus(3, ovrA, vld);
        btn_raw = 4'b0000;
        applyStimulus(10, ovrA, vld);
        checkOutput("glitch_no_event", 32'(vld), 32'd0);

        // Real dime press: event appears exactly 7 cycles after the raw rise.
        btn_raw = 4'b0100;
        applyStimulus(6, ovrA, vld);
        checkOutput("dime_latency_before", 32'(evt_valid), 32'd0);
        applyStimulus(1, ovrA, vld);
        checkOutput("dime_latency_valid", 32'(evt_valid), 32'd1);
        checkOutput("dime_latency_code", 32'(evt_code), 32'd1);
        applyStimulus(3, ovrA, vld);
        btn_raw = 4'b0000;
        applyStimulus(10, ovrA, vld);
        checkOutput("dime_held_code", 32'(evt_code), 32'd1);
        handshake();
        checkOutput("dime_consumed", 32'(evt_valid), 32'd0);
        applyStimulus(10, ovrA, vld);
        checkOutput("dime_single_event", 32'(vld), 32'd0);

        // Nickel held for 50 cycles gives exactly one event.
        btn_raw = 4'b1000;
        applyStimulus(50, ovrA, vld);
        checkOutput("hold_no_overrun", 32'(ovrA), 32'd0);
        checkOutput("hold_valid", 32'(evt_valid), 32'd1);
        checkOutput("hold_code", 32'(evt_code), 32'd0);
        handshake();
        checkOutput("hold_consumed", 32'(evt_valid), 32'd0);
        applyStimulus(5, ovrA, vld);
        checkOutput("hold_no_second_held", 32'(vld), 32'd0);
        btn_raw = 4'b0000;
        applyStimulus(10, ovrA, vld);
        checkOutput("hold_no_second_release", 32'(vld), 32'd0);

        // Quarter and clear together drain in priority order.
        btn_raw = 4'b0011;
        applyStimulus(10, ovrA, vld);
        checkOutput("simul_valid", 32'(evt_valid), 32'd1);
        checkOutput("simul_first_code", 32'(evt_code), 32'd2);
        handshake();
        checkOutput("simul_second_valid", 32'(evt_valid), 32'd1);
        checkOutput("simul_second_code", 32'(evt_code), 32'd3);
        handshake();
        checkOutput("simul_drained", 32'(evt_valid), 32'd0);
        btn_raw = 4'b0000;
        applyStimulus(10, ovrA, vld);

        // Dime pressed while clear is pending preempts it.
        btn_raw = 4'b0001;
        applyStimulus(10, ovrA, vld);
        checkOutput("preempt_clear_code", 32'(evt_code), 32'd3);
        btn_raw = 4'b0101;
        applyStimulus(6, ovrA, vld);
        checkOutput("preempt_stable_code", 32'(evt_code), 32'd3);
        applyStimulus(1, ovrA, vld);
        checkOutput("preempt_dime_code", 32'(evt_code), 32'd1);
        handshake();
        checkOutput("preempt_then_clear", 32'(evt_code), 32'd3);
        handshake();
        checkOutput("preempt_drained", 32'(evt_valid), 32'd0);
        btn_raw = 4'b0000;
        applyStimulus(10, ovrA, vld);

        // Second quarter press onto an unconsumed quarter is dropped.
        btn_raw = 4'b0010;
        applyStimulus(8, ovrA, vld);
        btn_raw = 4'b0000;
        applyStimulus(8, ovrA, vld);
        checkOutput("ovr_first_code", 32'(evt_code), 32'd2);
        btn_raw = 4'b0010;
        applyStimulus(10, ovrA, vld);
        checkOutput("ovr_pulse_count", 32'(ovrA), 32'd1);
        checkOutput("ovr_still_valid", 32'(evt_valid), 32'd1);
        handshake();
        checkOutput("ovr_one_event", 32'(evt_valid), 32'd0);
        btn_raw = 4'b0000;
        applyStimulus(10, ovrA, vld);

        // Second quarter rise lands on the consuming cycle: kept, no overrun.
        btn_raw = 4'b0010;
        applyStimulus(8, ovrA, vld);
        btn_raw = 4'b0000;
        applyStimulus(8, ovrA, vld);
        btn_raw = 4'b0010;
        applyStimulus(6, ovrA, vld);
        evt_ready = 1'b1;
        applyStimulus(1, ovrB, vld);
        evt_ready = 1'b0;
        checkOutput("setwins_valid", 32'(evt_valid), 32'd1);
        checkOutput("setwins_code", 32'(evt_code), 32'd2);
        applyStimulus(5, ovrC, vld);
        checkOutput("setwins_no_overrun", 32'(ovrA + ovrB + ovrC), 32'd0);
        handshake();
        checkOutput("setwins_drained", 32'(evt_valid), 32'd0);
        btn_raw = 4'b0000;
        applyStimulus(10, ovrA, vld);

        // Reset with two events pending and bean switch debounced.
        sw_raw  = 3'b100;
        btn_raw = 4'b1100;
        applyStimulus(10, ovrA, vld);
        checkOutput("prerst_sel", 32'(sel), 32'h4);
        checkOutput("prerst_code", 32'(evt_code), 32'd0);
        btn_raw = 4'b0000;
        rst_n   = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(evt_valid), 32'd0);
        checkOutput("midrst_sel", 32'(sel), 32'd0);
        checkOutput("midrst_code", 32'(evt_code), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(5, ovrA, vld);
        checkOutput("postrst_sel_early", 32'(sel), 32'd0);
        applyStimulus(1, ovrA, vld);
        checkOutput("postrst_sel", 32'(sel), 32'h4);
        applyStimulus(10, ovrA, vld);
        checkOutput("postrst_no_event", 32'(vld), 32'd0);

`ifdef COIN_TALLY_EN
        checkOutput("tally_reset", 32'(tally), 32'd0);
        evt_ready = 1'b1;
        repeat (300) begin
            btn_raw = 4'b1000;
            applyStimulus(8, ovrA, vld);
            btn_raw = 4'b0000;
            applyStimulus(8, ovrA, vld);
        end
        evt_ready = 1'b0;
        checkOutput("tally_saturated", 32'(tally), 32'hFF0000);
        checkOutput("tally_drained", 32'(evt_valid), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
